// File: rtl/halftone_pkg.sv
// Shared definitions for the ordered-dither halftone engine.
// Holds the FSM encoding, default widths, Bayer base matrices and pixel levels.
package halftone_pkg;

    localparam int AW_DEF = 18;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD,
        S_CMP,
        S_FIN
    } state_e;

    // 4x4 Bayer index matrix, indexed [y][x]
    localparam logic [3:0] M4 [4][4] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6},
        '{4'd3,  4'd11, 4'd1,  4'd9},
        '{4'd15, 4'd7,  4'd13, 4'd5}
    };

    // 2x2 seed used to expand M4 to an 8x8 matrix, indexed [y][x]
    localparam logic [1:0] M2 [2][2] = '{
        '{2'd0, 2'd2},
        '{2'd3, 2'd1}
    };

    localparam logic [7:0] PIX_BLACK = 8'h00;
    localparam logic [7:0] PIX_WHITE = 8'hFF;

endpackage

// File: rtl/bayer_threshold.sv
// Combinational Bayer threshold lookup for one pixel position.
// Ports: x_i[2:0], y_i[2:0] pixel coordinate LSBs; t_o[7:0] threshold.
// Macro HALFTONE_BAYER8_EN selects the 8x8 matrix; default is 4x4.
module bayer_threshold
    import halftone_pkg::*;
(
    input  logic [2:0] x_i,
    input  logic [2:0] y_i,
    output logic [7:0] t_o
);

`ifdef HALFTONE_BAYER8_EN
    logic [5:0] m8;

    // M8 = 4*M4[y%4][x%4] + M2[y/4][x/4]; T = M8*4+2
    always_comb begin
        m8  = {M4[y_i[1:0]][x_i[1:0]], 2'b00}
            + {4'b0000, M2[y_i[2]][x_i[2]]};
        t_o = {m8, 2'b10};
    end
`else
    logic unused_hi;

    // 4x4 only needs the low two coordinate bits
    assign unused_hi = x_i[2] ^ y_i[2];

    // T = M4*16+8
    always_comb begin
        t_o = {M4[y_i[1:0]][x_i[1:0]], 4'b1000};
    end
`endif

endmodule

// File: rtl/halftone_dither_ctrl.sv
// Raster-scan ordered-dither controller for a single-port grayscale frame RAM.
// Ports: CLK, RST (async high), START; BUSY, DONE status; RAM_REN/WEN/A/D/Q.
// Macro HALFTONE_BAYER8_EN switches the threshold to the 8x8 Bayer matrix.
module halftone_dither_ctrl
    import halftone_pkg::*;
#(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    output logic          BUSY,
    output logic          DONE,
    output logic          RAM_REN,
    output logic          RAM_WEN,
    output logic [AW-1:0] RAM_A,
    output logic [DW-1:0] RAM_D,
    input  logic [DW-1:0] RAM_Q
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    state_e        state_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [AW-1:0] addr_q;
    logic          busy_q;
    logic          done_q;
    logic          ren_q;
    logic          wen_q;

    logic          x_last;
    logic          last_px;
    logic [2:0]    x3;
    logic [2:0]    y3;
    logic [7:0]    thr;
    logic [DW-1:0] pix_out;

    assign x_last  = (x_q == XW'(IMG_W - 1));
    assign last_px = x_last && (y_q == YW'(IMG_H - 1));

    assign x3 = 3'(x_q);
    assign y3 = 3'(y_q);

    bayer_threshold u_thr (
        .x_i (x3),
        .y_i (y3),
        .t_o (thr)
    );

    // RAM_Q is only valid during CMP, so the write data is formed from it
    // directly rather than registered a cycle late.
    assign pix_out = (RAM_Q >= DW'(thr)) ? DW'(PIX_WHITE) : DW'(PIX_BLACK);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (START) begin
                        state_q <= S_RD;
                        busy_q  <= 1'b1;
                        ren_q   <= 1'b1;
                    end
                end
                S_RD: begin
                    state_q <= S_CMP;
                    ren_q   <= 1'b0;
                    wen_q   <= 1'b1;
                end
                S_CMP: begin
                    wen_q <= 1'b0;
                    if (last_px) begin
                        state_q <= S_FIN;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        x_q     <= '0;
                        y_q     <= '0;
                        addr_q  <= '0;
                    end else begin
                        state_q <= S_RD;
                        ren_q   <= 1'b1;
                        addr_q  <= addr_q + AW'(1);
                        if (x_last) begin
                            x_q <= '0;
                            y_q <= y_q + YW'(1);
                        end else begin
                            x_q <= x_q + XW'(1);
                        end
                    end
                end
                S_FIN: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign BUSY    = busy_q;
    assign DONE    = done_q;
    assign RAM_REN = ren_q;
    assign RAM_WEN = wen_q;

    // Bus is parked at zero whenever no access is in progress
    assign RAM_A = (ren_q || wen_q) ? addr_q : '0;
    assign RAM_D = wen_q ? pix_out : '0;

endmodule

// File: tb/tb_halftone_dither_ctrl.sv
// Self-checking bench for halftone_dither_ctrl on an 8x4 image.
// Behavioural RAM with registered Q; expected writes kept in a scoreboard queue.
module tb_halftone_dither_ctrl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int N  = W * H;
    localparam int AW = 18;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          START = 1'b0;
    logic          BUSY;
    logic          DONE;
    logic          RAM_REN;
    logic          RAM_WEN;
    logic [AW-1:0] RAM_A;
    logic [7:0]    RAM_D;
    logic [7:0]    RAM_Q;

    logic [7:0] mem [N];
    logic [7:0] pat [N];
    logic [7:0] img [N];
    logic       fill_en = 1'b0;

    typedef struct {
        int a;
        int d;
    } exp_t;

    exp_t q[$];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    halftone_dither_ctrl #(
        .IMG_W (W),
        .IMG_H (H),
        .AW    (AW),
        .DW    (8)
    ) dut (
        .CLK     (CLK),
        .RST     (RST),
        .START   (START),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .RAM_REN (RAM_REN),
        .RAM_WEN (RAM_WEN),
        .RAM_A   (RAM_A),
        .RAM_D   (RAM_D),
        .RAM_Q   (RAM_Q)
    );

    always @(posedge CLK) begin
        RAM_Q <= RAM_REN ? mem[RAM_A[4:0]] : 8'h00;
        if (RAM_WEN)
            mem[RAM_A[4:0]] <= RAM_D;
        if (fill_en)
            for (int i = 0; i < N; i++)
                mem[i] <= pat[i];
    end

    function automatic int thr(input int x, input int y);
        int m4[16] = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
`ifdef HALFTONE_BAYER8_EN
        int m2[4] = '{0, 2, 3, 1};
        int m8;
        m8 = 4 * m4[(y % 4) * 4 + (x % 4)] + m2[((y % 8) / 4) * 2 + (x % 8) / 4];
        return m8 * 4 + 2;
`else
        return m4[(y % 4) * 4 + (x % 4)] * 16 + 8;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] outs();
        return 32'({BUSY, DONE, RAM_REN, RAM_WEN, RAM_A, RAM_D});
    endfunction

    task automatic fill(input bit ramp, input int v);
        for (int i = 0; i < N; i++) begin
            pat[i] = ramp ? 8'((i * 8) + 3) : 8'(v);
            img[i] = pat[i];
        end
        @(negedge CLK) fill_en = 1'b1;
        @(negedge CLK) fill_en = 1'b0;
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < N; i++)
            check(tag, 32'(mem[i]), 32'(img[i]));
    endtask

    task automatic run_pass(input int restart_at, input int abort_at,
                            input bit hold);
        int   cyc;
        int   busy_n;
        int   done_n;
        int   exp_rd;
        bit   prev_ren;
        int   prev_a;
        exp_t e;
        q.delete();
        for (int i = 0; i < N; i++) begin
            e.a = i;
            e.d = (int'(img[i]) >= thr(i % W, i / W)) ? 255 : 0;
            q.push_back(e);
        end
        @(negedge CLK) START = 1'b1;
        @(negedge CLK);
        if (!hold) START = 1'b0;
        check("first_ren", 32'(RAM_REN), 1);
        check("first_a", 32'(RAM_A), 0);
        cyc = 0; busy_n = 0; done_n = 0; exp_rd = 0;
        prev_ren = 1'b0; prev_a = -1;
        while (cyc < 200) begin
            check("ren_wen_excl", 32'(RAM_REN & RAM_WEN), 0);
            if (!RAM_REN && !RAM_WEN)
                check("idle_bus", 32'({RAM_A, RAM_D}), 0);
            if (BUSY) busy_n++;
            if (RAM_REN) begin
                check("rd_addr", 32'(RAM_A), 32'(exp_rd));
                exp_rd++;
                prev_a = int'(RAM_A);
            end
            if (RAM_WEN) begin
                check("wr_after_rd", 32'(prev_ren), 1);
                check("wr_same_addr", 32'(RAM_A), 32'(prev_a));
                if (q.size() == 0) begin
                    check("sb_nonempty", 0, 1);
                end else begin
                    e = q.pop_front();
                    check("wr_addr", 32'(RAM_A), 32'(e.a));
                    check("wr_data", 32'(RAM_D), 32'(e.d));
                    img[e.a] = 8'(e.d);
                end
            end
            prev_ren = RAM_REN;
            if (DONE) begin
                done_n++;
                break;
            end
            if (restart_at >= 0 && cyc == restart_at) START = 1'b1;
            if (restart_at >= 0 && cyc == restart_at + 1) START = 1'b0;
            if (cyc == abort_at) begin
                RST = 1'b1;
                #1;
                check("rst_async_outs", outs(), 0);
                break;
            end
            @(negedge CLK);
            cyc++;
        end
        if (abort_at >= 0) begin
            @(negedge CLK) RST = 1'b0;
            for (int k = 0; k < 6; k++) begin
                @(negedge CLK);
                check("abort_no_done", 32'({DONE, BUSY}), 0);
            end
        end else begin
            check("done_seen", 32'(done_n), 1);
            check("busy_cycles", 32'(busy_n), 2 * N);
            check("pass_len", 32'(cyc), 2 * N);
            check("sb_empty", 32'(q.size()), 0);
            check("fin_busy", 32'(BUSY), 0);
            @(negedge CLK);
            check("done_pulse", 32'({DONE, BUSY, RAM_REN}), 0);
            if (hold) begin
                @(negedge CLK);
                check("retrig_ren", 32'({BUSY, RAM_REN}), 3);
                check("retrig_a", 32'(RAM_A), 0);
                START = 1'b0;
                RST = 1'b1;
                #1;
                check("retrig_rst", outs(), 0);
                @(negedge CLK) RST = 1'b0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pat[i] = 8'h00;
            img[i] = 8'h00;
        end
        repeat (3) @(negedge CLK);
        check("reset_outs", outs(), 0);
        RST = 1'b0;
        @(negedge CLK);
        check("idle_outs", outs(), 0);

        fill(1'b0, 128);
        run_pass(-1, -1, 1'b0);
        check_mem("mem_128");
        check("px00_128", 32'(mem[0]), 32'hFF);
        check("px10_128", 32'(mem[1]), 32'h00);
`ifdef HALFTONE_BAYER8_EN
        check("px40_128", 32'(mem[4]), 32'hFF);
`else
        check("px01_128", 32'(mem[8]), 32'h00);
`endif

        fill(1'b0, 0);
        run_pass(-1, -1, 1'b0);
        for (int i = 0; i < N; i++)
            check("all_zero", 32'(mem[i]), 32'h00);

        fill(1'b0, 255);
        run_pass(-1, -1, 1'b0);
        for (int i = 0; i < N; i++)
            check("all_ff", 32'(mem[i]), 32'hFF);

        fill(1'b1, 0);
        run_pass(10, -1, 1'b0);
        check_mem("mem_ramp");
        repeat (3) @(negedge CLK);
        check("no_queued_start", 32'({BUSY, RAM_REN}), 0);
        run_pass(-1, -1, 1'b0);
        check_mem("mem_binary");

        fill(1'b1, 0);
        run_pass(-1, 20, 1'b0);
        check_mem("mem_abort");
        for (int i = 10; i < N; i++)
            check("abort_untouched", 32'(mem[i]), 32'(pat[i]));
        run_pass(-1, -1, 1'b0);
        check_mem("mem_after_abort");

        fill(1'b0, 200);
        run_pass(-1, -1, 1'b1);
        check_mem("mem_hold");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
